// File: rtl/atari_mouse_ps2.sv
// Rebuilds 25-bit PS/2 mouse packets from Atari ST quadrature signals.
// Steps are decoded per axis, accumulated with saturation, and reported once per timer slot.
module atari_mouse_ps2 #(
   parameter int REPORT_DIV = 8192
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic [6:0]  mouse_atari,
   output logic [24:0] ps2_mouse
);

   localparam int            TW         = $clog2(REPORT_DIV);
   localparam logic [TW-1:0] TIMER_LAST = TW'(REPORT_DIV - 1);

   logic [6:0]    sync1;
   logic [6:0]    sync2;
   logic [1:0]    warm;
   logic [1:0]    prev_x;
   logic [1:0]    prev_y;
   logic [8:0]    acc_x;
   logic [8:0]    acc_y;
   logic          ovf_x;
   logic          ovf_y;
   logic [2:0]    last_btn;
   logic [TW-1:0] timer;

   logic [1:0]    step_x;
   logic [1:0]    step_y;
   logic [9:0]    sum_x;
   logic [9:0]    sum_y;
   logic          slot;
   logic          emit;
   logic [24:0]   next_packet;

   // Two's complement step: 2'b01 = +1, 2'b11 = -1, 2'b00 = none or illegal.
   function automatic logic [1:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] step;
      case ({prev, cur})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = 2'b01;
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = 2'b11;
         default:                                step = 2'b00;
      endcase
      return step;
   endfunction

   // Result is {overflow, saturated sum}; overflow shows up as bits 9 and 8 disagreeing.
   function automatic logic [9:0] sat_add(input logic [8:0] acc, input logic [1:0] step);
      logic [9:0] sum;
      sum = {acc[8], acc} + {{8{step[1]}}, step};
      if (sum[9] != sum[8]) begin
         return sum[9] ? {1'b1, 9'h100} : {1'b1, 9'h0FF};
      end
      return {1'b0, sum[8:0]};
   endfunction

   always_comb begin
      step_x = 2'b00;
      step_y = 2'b00;
      if (warm == 2'd3) begin
         step_x = quad_step(prev_x, sync2[1:0]);
         step_y = 2'b00 - quad_step(prev_y, sync2[3:2]);
      end
   end

   assign sum_x = sat_add(acc_x, step_x);
   assign sum_y = sat_add(acc_y, step_y);
   assign slot  = (timer == TIMER_LAST);
   assign emit  = slot && ((acc_x != '0) || (acc_y != '0) || (sync2[6:4] != last_btn));

   assign next_packet = {~ps2_mouse[24], acc_y[7:0], acc_x[7:0], ovf_y, ovf_x,
                         acc_y[8], acc_x[8], 1'b1, sync2[6:4]};

   always_ff @(posedge clk) begin
      if (ce) begin
         if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            prev_x <= '0;
            prev_y <= '0;
            warm   <= '0;
            timer  <= '0;
         end else begin
            sync1  <= mouse_atari;
            sync2  <= sync1;
            prev_x <= sync2[1:0];
            prev_y <= sync2[3:2];
            if (warm != 2'd3) begin
               warm <= warm + 2'd1;
            end
            timer <= slot ? '0 : timer + TW'(1);
         end
      end
   end

   // At an emitting slot the accumulators restart from this cycle's step so no motion is dropped.
   always_ff @(posedge clk) begin
      if (ce) begin
         if (reset) begin
            acc_x     <= '0;
            acc_y     <= '0;
            ovf_x     <= 1'b0;
            ovf_y     <= 1'b0;
            last_btn  <= '0;
            ps2_mouse <= '0;
         end else if (emit) begin
            ps2_mouse <= next_packet;
            last_btn  <= sync2[6:4];
            acc_x     <= {{7{step_x[1]}}, step_x};
            acc_y     <= {{7{step_y[1]}}, step_y};
            ovf_x     <= 1'b0;
            ovf_y     <= 1'b0;
         end else begin
            acc_x <= sum_x[8:0];
            acc_y <= sum_y[8:0];
            ovf_x <= ovf_x | sum_x[9];
            ovf_y <= ovf_y | sum_y[9];
         end
      end
   end

endmodule

// File: tb/tb_atari_mouse_ps2.sv
// Self-checking bench for atari_mouse_ps2: directed vector table and corner sequences
// plus randomized traffic, all checked every cycle against a position/phase reference model.
module tb_atari_mouse_ps2;

   localparam int RD = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic [6:0]  mouse_atari;
   logic [24:0] ps2_mouse;

   atari_mouse_ps2 #(.REPORT_DIV(RD)) dut (
      .clk         (clk),
      .reset       (reset),
      .ce          (ce),
      .mouse_atari (mouse_atari),
      .ps2_mouse   (ps2_mouse)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Quadrature position is tracked as a phase 0..3; gray_of maps it onto the wires.
   int         phase_of [4] = '{0, 3, 1, 2};
   logic [1:0] gray_of  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   int         x_phase   = 0;
   int         y_phase   = 0;
   logic [2:0] btn_state = 3'b000;
   bit         strobe_exp = 1'b0;

   logic [6:0]  m_pipe [2];
   logic [1:0]  m_prev_x;
   logic [1:0]  m_prev_y;
   int          m_age;
   int          m_tick;
   int          m_ax;
   int          m_ay;
   bit          m_ox;
   bit          m_oy;
   logic [2:0]  m_last_btn;
   logic [24:0] exp_ps2;
   bit          m_slot_hit;

   typedef struct {
      string      name;
      int         x_steps;
      int         y_steps;
      logic [2:0] btn;
      logic [23:0] exp_pkt;
   } vec_t;

   vec_t vecs [8];

   function automatic int quad_delta(input logic [1:0] from, input logic [1:0] to);
      int d;
      d = (phase_of[to] - phase_of[from] + 4) % 4;
      return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic logic [6:0] cur_in();
      return {btn_state, gray_of[y_phase], gray_of[x_phase]};
   endfunction

   task automatic model_update(input logic [6:0] m, input logic r);
      logic [6:0] seen;
      int dx, dy, nx, ny;
      bit slot;
      m_slot_hit = 1'b0;
      if (r) begin
         m_pipe[0] = '0; m_pipe[1] = '0; m_prev_x = '0; m_prev_y = '0;
         m_age = 0; m_tick = 0; m_ax = 0; m_ay = 0; m_ox = 0; m_oy = 0;
         m_last_btn = '0; exp_ps2 = '0;
      end else begin
         seen = m_pipe[1];
         dx = (m_age >= 3) ? quad_delta(m_prev_x, seen[1:0]) : 0;
         dy = (m_age >= 3) ? -quad_delta(m_prev_y, seen[3:2]) : 0;
         slot = (m_tick == RD - 1);
         m_slot_hit = slot;
         if (slot && (m_ax != 0 || m_ay != 0 || seen[6:4] != m_last_btn)) begin
            exp_ps2 = {~exp_ps2[24], 8'(m_ay), 8'(m_ax), m_oy, m_ox,
                       (m_ay < 0), (m_ax < 0), 1'b1, seen[6:4]};
            m_last_btn = seen[6:4];
            m_ax = dx; m_ay = dy; m_ox = 0; m_oy = 0;
         end else begin
            nx = m_ax + dx;
            ny = m_ay + dy;
            if (nx > 255)  begin nx = 255;  m_ox = 1; end
            if (nx < -256) begin nx = -256; m_ox = 1; end
            if (ny > 255)  begin ny = 255;  m_oy = 1; end
            if (ny < -256) begin ny = -256; m_oy = 1; end
            m_ax = nx; m_ay = ny;
         end
         m_prev_x = seen[1:0];
         m_prev_y = seen[3:2];
         m_age    = (m_age < 3) ? m_age + 1 : 3;
         m_tick   = (m_tick + 1) % RD;
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = m;
      end
   endtask

   task automatic checkOutput(input string name, input logic [24:0] expected);
      tests_run++;
      if (ps2_mouse !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: ps2_mouse=%h expected=%h at %0t", name, ps2_mouse, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] m, input logic r, input logic c);
      mouse_atari = m;
      reset       = r;
      ce          = c;
      @(posedge clk);
      if (c) model_update(m, r);
      @(negedge clk);
      checkOutput("cycle", exp_ps2);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(cur_in(), 1'b0, 1'b1);
   endtask

   task automatic run_to_slot();
      int n;
      n = 0;
      do begin
         applyStimulus(cur_in(), 1'b0, 1'b1);
         n++;
      end while (!m_slot_hit && n < RD + 4);
      if (!m_slot_hit) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL slot_bound: no slot after %0d cycles, required within %0d", n, RD);
      end
   endtask

   task automatic step_x(input int dir);
      x_phase = (x_phase + dir + 4) % 4;
   endtask

   task automatic step_y(input int dir);
      y_phase = (y_phase + dir + 4) % 4;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int nsteps, mode, r;
      logic rst;

      vecs[0] = '{"x_fwd4",      4,  0, 3'b000, 24'h000408};
      vecs[1] = '{"y_fwd3",      0,  3, 3'b000, 24'hFD0028};
      vecs[2] = '{"y_rev2",      0, -2, 3'b000, 24'h020008};
      vecs[3] = '{"x_rev5",     -5,  0, 3'b000, 24'h00FB18};
      vecs[4] = '{"btn_left",    0,  0, 3'b001, 24'h000009};
      vecs[5] = '{"btn_release", 0,  0, 3'b000, 24'h000008};
      vecs[6] = '{"xy_mid",      2, -1, 3'b100, 24'h01020C};
      vecs[7] = '{"mid_release", 0,  0, 3'b000, 24'h000008};

      repeat (4) applyStimulus(7'h00, 1'b1, 1'b1);
      checkOutput("reset_value", 25'h0000000);
      idle(3 * RD);
      checkOutput("idle_no_packet", 25'h0000000);

      run_to_slot();
      for (int i = 0; i < 8; i++) begin
         btn_state = vecs[i].btn;
         nsteps = (iabs(vecs[i].x_steps) > iabs(vecs[i].y_steps)) ?
                  iabs(vecs[i].x_steps) : iabs(vecs[i].y_steps);
         for (int s = 0; s < nsteps; s++) begin
            if (s < iabs(vecs[i].x_steps)) step_x((vecs[i].x_steps > 0) ? 1 : -1);
            if (s < iabs(vecs[i].y_steps)) step_y((vecs[i].y_steps > 0) ? 1 : -1);
            idle(16);
         end
         idle(4);
         run_to_slot();
         strobe_exp = ~strobe_exp;
         checkOutput(vecs[i].name, {strobe_exp, vecs[i].exp_pkt});
      end

      run_to_slot();
      checkOutput("quiet_slot", {strobe_exp, 24'h000008});

      // Saturation: far more forward steps than the accumulator can hold in one slot.
      for (int s = 0; s < 300; s++) begin
         step_x(1);
         idle(2);
      end
      run_to_slot();
      strobe_exp = ~strobe_exp;
      checkOutput("sat_packet", {strobe_exp, 24'h00FF48});
      step_x(1);
      idle(16);
      run_to_slot();
      strobe_exp = ~strobe_exp;
      checkOutput("sat_ovf_cleared", {strobe_exp, 24'h000108});

      for (int s = 0; s < 100; s++) begin
         x_phase = (x_phase + 2) % 4;
         idle(8);
      end
      run_to_slot();
      checkOutput("illegal_no_packet", {strobe_exp, 24'h000108});

      // Second step lands in the accumulator exactly on the slot edge.
      step_x(1);
      idle(16);
      while (m_tick != RD - 3) idle(1);
      step_x(1);
      idle(1);
      run_to_slot();
      strobe_exp = ~strobe_exp;
      checkOutput("step_on_slot_first", {strobe_exp, 24'h000108});
      run_to_slot();
      strobe_exp = ~strobe_exp;
      checkOutput("step_on_slot_carry", {strobe_exp, 24'h000108});

      for (int s = 0; s < 5; s++) begin
         step_x(1);
         idle(16);
      end
      idle(100);
      applyStimulus(cur_in(), 1'b1, 1'b1);
      applyStimulus(cur_in(), 1'b1, 1'b1);
      strobe_exp = 1'b0;
      checkOutput("reset_mid_clear", 25'h0000000);
      run_to_slot();
      checkOutput("reset_mid_no_pkt", 25'h0000000);
      step_x(1);
      idle(16);
      run_to_slot();
      strobe_exp = ~strobe_exp;
      checkOutput("post_reset_first", {strobe_exp, 24'h000108});

      for (int i = 0; i < 6000; i++) begin
         mode = (i / 1000) % 3;
         r = $urandom_range(0, 99);
         if (mode == 1 && r < 50) begin
            step_x(1);
         end else if (mode == 2 && r < 50) begin
            step_y(-1);
         end else if (r < 15) begin
            step_x($urandom_range(0, 1) ? 1 : -1);
         end else if (r < 30) begin
            step_y($urandom_range(0, 1) ? 1 : -1);
         end else if (r < 32) begin
            x_phase = (x_phase + 2) % 4;
         end
         if ($urandom_range(0, 199) == 0) btn_state = 3'($urandom_range(0, 7));
         rst = ($urandom_range(0, 2999) == 0);
         applyStimulus(cur_in(), rst, ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
